ls_unit: RTL and testbench
==========================

Name: ls_unit

Overview:
- Load/store execution unit directly downstream of the load/store buffer. Accepts one in-order memory op per handshake: base operand, store data, immediate, destination tag/name, opcode.
- Performs byte-serial accesses on the 8-bit data-memory port.
- Broadcasts load results on the LS result bus, which feeds back into the reservation stations and the LS buffer.

Parameters:
DATA_W, 32, data/address width
TAG_W, 4, rename tag width
NAME_W, 5, architectural register name width
OP_W, 6, opcode width; encodings are the shared defines LB, LH, LW, LBU, LHU, SB, SH, SW

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
work_en  in  1  issue valid from LS buffer
in_base  in  DATA_W  base address operand
in_sdata  in  DATA_W  store data operand
in_imm  in  DATA_W  sign-extended offset
in_tag  in  TAG_W  destination tag
in_name  in  NAME_W  destination register name
in_op  in  OP_W  opcode
ls_ready  out  1  read-enable to LS buffer
mem_req  out  1  byte request valid
mem_we  out  1  1 = write byte
mem_addr  out  DATA_W  byte address
mem_wdata  out  8  write byte
mem_ack  in  1  request accepted this cycle
mem_rvalid  in  1  read byte valid
mem_rdata  in  8  read byte
out_en  out  1  result broadcast valid
out_tag  out  TAG_W  result tag
out_name  out  NAME_W  result name
out_data  out  DATA_W  result data

Behaviour:
- Reset (async): state IDLE.
  - ls_ready = 1; mem_req = mem_we = 0; mem_addr = mem_wdata = 0; out_en = 0; out_tag/out_name/out_data = 0; byte counter = 0.
  - Reset mid-access abandons the op. No further requests; no broadcast.
- ls_ready is combinational: (state == IDLE) && !work_en.
  - The buffer registers its issue one cycle after sampling ready. Dropping ready during the work_en cycle prevents a back-to-back double issue.
- Capture: in IDLE with work_en = 1 at cycle C, latch the following.
  - addr = in_base + in_imm (mod 2^32).
  - sdata, tag, name, op.
  - N = 1 (B/BU), 2 (H/HU), 4 (W).
  - Next state REQ.
- Capture with an unknown opcode: no memory traffic, no broadcast; remain IDLE.
- work_en outside IDLE is ignored. This is a protocol violation that cannot occur while ls_ready is obeyed.
- REQ: drive the request for byte k.
  - mem_req = 1, mem_addr = addr + k, mem_we = isStore, mem_wdata = sdata[8k+7:8k].
  - Hold all request outputs stable until mem_ack.
  - Store, on ack: k++. If k == N, go to IDLE; else stay in REQ.
  - Load, on ack: go to WAIT, mem_req = 0.
- WAIT (loads only): mem_req = 0.
  - On mem_rvalid, write mem_rdata into result byte k (little-endian), then k++.
  - If k == N, go to WB; else go to REQ.
  - mem_rvalid in the same cycle as ack is ignored; data is expected the cycle after ack or later.
- WB: out_en = 1 for exactly one cycle with latched tag/name.
  - out_data: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW as-is.
  - Next state IDLE; out_en returns to 0 and out_* return to 0.
- Stores never assert out_en.
- Unaligned addresses are legal; byte-serial access handles them. Address wraps at 2^32.
- Timing, ack immediate, rvalid one cycle after ack:
  - Load: byte k requested at C+1+2k; out_en at C+2N+1; ls_ready high again at C+2N+2.
  - Store: byte k written at C+1+k; ls_ready high at C+N+1.
- Ack stalls extend REQ indefinitely. rvalid delays extend WAIT. There is no timeout.

Test Plan:
- LW, base 0x100, imm 0x4, memory 0x104..0x107 = 78 56 34 12, tag 3, name 5 -> four byte reads at 0x104..0x107; out_en one cycle at C+9 with out_data 0x12345678, out_tag 3, out_name 5.
- LB, addr 0x20, byte 0x80 -> out_data 0xFFFFFF80. LBU same -> 0x00000080. LH at 0x21 (unaligned), bytes FE FF -> 0xFFFFFFFE. LHU -> 0x0000FFFE.
- SW, sdata 0xDEADBEEF, base 0x200, imm 0xFFFFFFFC -> writes EF BE AD DE to 0x1FC..0x1FF; out_en never asserts; ls_ready high at C+5.
- SH with mem_ack withheld 3 cycles on byte 0 -> mem_addr/mem_wdata/mem_req held stable; only 2 writes occur; ls_ready low until completion.
- Back-to-back: work_en pulses on consecutive issues -> ls_ready low in every capture cycle and throughout each access; no op dropped or duplicated.
- Assert rst during WAIT of an LW -> all outputs 0 immediately; ls_ready = 1; no out_en after release; next LB completes correctly.

Source files
------------

// File: rtl/ls_unit_if.sv
// Issue, byte-memory and result-broadcast signals of the load/store unit.
// "master" is the load/store unit itself; "slave" is its environment (LS buffer, memory, consumers).
interface ls_unit_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int NAME_W = 5,
    parameter int OP_W   = 6
);
    logic              work_en;
    logic [DATA_W-1:0] in_base;
    logic [DATA_W-1:0] in_sdata;
    logic [DATA_W-1:0] in_imm;
    logic [TAG_W-1:0]  in_tag;
    logic [NAME_W-1:0] in_name;
    logic [OP_W-1:0]   in_op;
    logic              ls_ready;

    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ack;
    logic              mem_rvalid;
    logic [7:0]        mem_rdata;

    logic              out_en;
    logic [TAG_W-1:0]  out_tag;
    logic [NAME_W-1:0] out_name;
    logic [DATA_W-1:0] out_data;

    modport master (
        input  work_en, in_base, in_sdata, in_imm, in_tag, in_name, in_op,
        input  mem_ack, mem_rvalid, mem_rdata,
        output ls_ready, mem_req, mem_we, mem_addr, mem_wdata,
        output out_en, out_tag, out_name, out_data
    );

    modport slave (
        output work_en, in_base, in_sdata, in_imm, in_tag, in_name, in_op,
        output mem_ack, mem_rvalid, mem_rdata,
        input  ls_ready, mem_req, mem_we, mem_addr, mem_wdata,
        input  out_en, out_tag, out_name, out_data
    );
endinterface

// File: rtl/ls_unit.sv
// Load/store execution unit: one in-order op at a time, performed byte-serially over an
// 8-bit memory port; load results are broadcast for one cycle on the result bus.
module ls_unit #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int NAME_W = 5,
    parameter int OP_W   = 6,
    parameter logic [OP_W-1:0] OP_LB  = OP_W'(1),
    parameter logic [OP_W-1:0] OP_LH  = OP_W'(2),
    parameter logic [OP_W-1:0] OP_LW  = OP_W'(3),
    parameter logic [OP_W-1:0] OP_LBU = OP_W'(4),
    parameter logic [OP_W-1:0] OP_LHU = OP_W'(5),
    parameter logic [OP_W-1:0] OP_SB  = OP_W'(6),
    parameter logic [OP_W-1:0] OP_SH  = OP_W'(7),
    parameter logic [OP_W-1:0] OP_SW  = OP_W'(8)
) (
    input  logic      clk,
    input  logic      rst,
    ls_unit_if.master bus
);
    localparam int NB = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] sdata_q, sdata_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [NAME_W-1:0] name_q, name_d;
    logic [2:0]        size_q, size_d;
    logic              store_q, store_d;
    logic              sext_q, sext_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q;

    logic              dec_valid, dec_store, dec_sext;
    logic [2:0]        dec_size;
    logic [2:0]        cnt_inc;
    logic              rd_fire;
    logic [NB-1:0]     lane_we;
    logic [DATA_W-1:0] ext_data;

    always_comb begin
        dec_valid = 1'b1;
        dec_store = 1'b0;
        dec_sext  = 1'b0;
        dec_size  = 3'd1;
        case (bus.in_op)
            OP_LB:   dec_sext = 1'b1;
            OP_LBU:  dec_size = 3'd1;
            OP_LH:   begin dec_size = 3'd2; dec_sext = 1'b1; end
            OP_LHU:  dec_size = 3'd2;
            OP_LW:   dec_size = 3'd4;
            OP_SB:   dec_store = 1'b1;
            OP_SH:   begin dec_size = 3'd2; dec_store = 1'b1; end
            OP_SW:   begin dec_size = 3'd4; dec_store = 1'b1; end
            default: dec_valid = 1'b0;
        endcase
    end

    assign cnt_inc = cnt_q + 3'd1;
    // Read data arriving in the ack cycle is not accepted: only WAIT listens to rvalid.
    assign rd_fire = (state_q == WAIT) && bus.mem_rvalid;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sdata_d = sdata_q;
        tag_d   = tag_q;
        name_d  = name_q;
        size_d  = size_q;
        store_d = store_q;
        sext_d  = sext_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.work_en && dec_valid) begin
                    addr_d  = bus.in_base + bus.in_imm;
                    sdata_d = bus.in_sdata;
                    tag_d   = bus.in_tag;
                    name_d  = bus.in_name;
                    size_d  = dec_size;
                    store_d = dec_store;
                    sext_d  = dec_sext;
                    cnt_d   = 3'd0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.mem_ack) begin
                    if (store_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == size_q) state_d = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.mem_rvalid) begin
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == size_q) ? WB : REQ;
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            sdata_q <= '0;
            tag_q   <= '0;
            name_q  <= '0;
            size_q  <= 3'd1;
            store_q <= 1'b0;
            sext_q  <= 1'b0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            tag_q   <= tag_d;
            name_q  <= name_d;
            size_q  <= size_d;
            store_q <= store_d;
            sext_q  <= sext_d;
            cnt_q   <= cnt_d;
        end
    end

    // Little-endian assembly: returned byte k lands in lane k.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        assign lane_we[gi] = rd_fire && (cnt_q == 3'(gi));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (lane_we[b]) rdata_q[8*b +: 8] <= bus.mem_rdata;
            end
        end
    end

    always_comb begin
        case (size_q)
            3'd1:    ext_data = {{(DATA_W-8){sext_q & rdata_q[7]}}, rdata_q[7:0]};
            3'd2:    ext_data = {{(DATA_W-16){sext_q & rdata_q[15]}}, rdata_q[15:0]};
            default: ext_data = rdata_q;
        endcase
    end

    // Dropping ready in the issue cycle keeps the buffer from issuing twice back-to-back.
    assign bus.ls_ready  = (state_q == IDLE) && !bus.work_en;
    assign bus.mem_req   = (state_q == REQ);
    assign bus.mem_we    = (state_q == REQ) && store_q;
    assign bus.mem_addr  = (state_q == REQ) ? addr_q + DATA_W'(cnt_q) : '0;
    assign bus.mem_wdata = (state_q == REQ) ? sdata_q[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;
    assign bus.out_en    = (state_q == WB);
    assign bus.out_tag   = (state_q == WB) ? tag_q : '0;
    assign bus.out_name  = (state_q == WB) ? name_q : '0;
    assign bus.out_data  = (state_q == WB) ? ext_data : '0;
endmodule

// File: tb/tb_ls_unit.sv
// Bench for ls_unit: directed spec cases plus random op streams against a transaction-level
// model (expected byte accesses and broadcasts per op) checked every cycle.
module tb_ls_unit;
    localparam logic [5:0] OP_LB  = 6'h01;
    localparam logic [5:0] OP_LH  = 6'h02;
    localparam logic [5:0] OP_LW  = 6'h03;
    localparam logic [5:0] OP_LBU = 6'h04;
    localparam logic [5:0] OP_LHU = 6'h05;
    localparam logic [5:0] OP_SB  = 6'h06;
    localparam logic [5:0] OP_SH  = 6'h07;
    localparam logic [5:0] OP_SW  = 6'h08;
    localparam logic [5:0] OP_BAD = 6'h3F;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ls_unit_if #(.DATA_W(32), .TAG_W(4), .NAME_W(5), .OP_W(6)) bus();

    ls_unit #(.DATA_W(32), .TAG_W(4), .NAME_W(5), .OP_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // ---------------- memories: reference (model) and physical (responder) ----------------
    logic [7:0] ref_mem  [logic [31:0]];
    logic [7:0] phys_mem [logic [31:0]];

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ (a[15:8] * 8'd3) ^ 8'h5C;
    endfunction
    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction
    function automatic logic [7:0] phys_rd(input logic [31:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : dflt(a);
    endfunction
    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        ref_mem[a]  = d;
        phys_mem[a] = d;
    endtask

    // ---------------- memory responder ----------------
    bit  rand_mode   = 0;
    int  stall_force = 0;
    int  delay_force = -1;
    bit  rd_ack_seen = 0;
    int  wr_count    = 0;
    bit  rd_pend;
    int  rd_wait;
    logic [7:0] rd_byte;

    initial begin
        bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 8'h00;
        rd_pend = 0; rd_wait = 0; rd_byte = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 8'h00;
            if (rst) begin
                rd_pend = 0;
            end else if (rd_pend) begin
                if (rd_wait == 0) begin
                    bus.mem_rvalid = 1'b1; bus.mem_rdata = rd_byte; rd_pend = 0;
                end else begin
                    rd_wait--;
                end
            end else if (bus.mem_req) begin
                if (stall_force > 0) begin
                    stall_force--;
                end else if (!(rand_mode && $urandom_range(0, 3) == 0)) begin
                    bus.mem_ack = 1'b1;
                    if (bus.mem_we) begin
                        phys_mem[bus.mem_addr] = bus.mem_wdata;
                        wr_count++;
                    end else begin
                        rd_pend = 1; rd_ack_seen = 1;
                        rd_byte = phys_rd(bus.mem_addr);
                        rd_wait = (delay_force >= 0) ? delay_force : (rand_mode ? int'($urandom_range(0, 2)) : 0);
                        // junk data in the ack cycle must be ignored
                        if (rand_mode && $urandom_range(0, 1) == 1) begin
                            bus.mem_rvalid = 1'b1; bus.mem_rdata = ~rd_byte;
                        end
                    end
                end
            end
        end
    end

    // ---------------- transaction-level model and per-cycle compare ----------------
    typedef struct { logic [31:0] addr; logic we; logic [7:0] wdata; logic last; } acc_t;
    typedef struct { logic [3:0] tag; logic [4:0] name; logic [31:0] data; } bc_t;
    acc_t acc_q[$];
    bc_t  bc_q[$];
    bit   outstanding = 0;
    int   bc_count = 0;
    int   bc_cyc = 0;
    logic [31:0] last_bc_data;
    logic [3:0]  last_bc_tag;
    logic [4:0]  last_bc_name;
    bit   prev_stall = 0;
    logic [31:0] prev_addr;
    logic [7:0]  prev_wdata;
    logic        prev_we;

    task automatic model_capture();
        int n; bit st; bit sx; bit ok;
        logic [31:0] a; logic [31:0] v;
        acc_t e; bc_t b;
        n = 1; st = 0; sx = 0; ok = 1;
        case (bus.in_op)
            OP_LB:  begin n = 1; sx = 1; end
            OP_LBU: n = 1;
            OP_LH:  begin n = 2; sx = 1; end
            OP_LHU: n = 2;
            OP_LW:  n = 4;
            OP_SB:  begin n = 1; st = 1; end
            OP_SH:  begin n = 2; st = 1; end
            OP_SW:  begin n = 4; st = 1; end
            default: ok = 0;
        endcase
        if (!ok) return;
        a = bus.in_base + bus.in_imm;
        v = 32'h0;
        for (int k = 0; k < n; k++) begin
            e.addr  = a + 32'(k);
            e.we    = st;
            e.wdata = st ? bus.in_sdata[8*k +: 8] : 8'h00;
            e.last  = (k == n - 1);
            acc_q.push_back(e);
            if (st) ref_mem[e.addr] = e.wdata;
            else    v = v | (32'(ref_rd(e.addr)) << (8 * k));
        end
        if (!st) begin
            if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            b.tag = bus.in_tag; b.name = bus.in_name; b.data = v;
            bc_q.push_back(b);
        end
        outstanding = 1;
    endtask

    always @(negedge clk) begin
        acc_t e; bc_t b;
        if (rst) begin
            acc_q.delete(); bc_q.delete();
            outstanding = 0; prev_stall = 0;
        end else begin
            chk("ls_ready", bus.ls_ready, !outstanding && !bus.work_en);
            if (prev_stall) begin
                chk("hold_req", bus.mem_req, 1'b1);
                chk("hold_addr", bus.mem_addr, prev_addr);
                chk("hold_we", bus.mem_we, prev_we);
                chk("hold_wdata", bus.mem_wdata, prev_wdata);
            end
            if (bus.mem_req) begin
                chk("req_allowed", {outstanding, acc_q.size() > 0}, 2'b11);
                if (bus.mem_ack && acc_q.size() > 0) begin
                    e = acc_q.pop_front();
                    chk("mem_addr", bus.mem_addr, e.addr);
                    chk("mem_we", bus.mem_we, e.we);
                    if (e.we) chk("mem_wdata", bus.mem_wdata, e.wdata);
                    if (e.last && e.we) outstanding = 0;
                end
            end
            prev_stall = bus.mem_req && !bus.mem_ack;
            prev_addr  = bus.mem_addr;
            prev_we    = bus.mem_we;
            prev_wdata = bus.mem_wdata;
            if (bus.out_en) begin
                chk("bc_allowed", {bc_q.size() > 0, acc_q.size() == 0}, 2'b11);
                if (bc_q.size() > 0) begin
                    b = bc_q.pop_front();
                    chk("out_tag", bus.out_tag, b.tag);
                    chk("out_name", bus.out_name, b.name);
                    chk("out_data", bus.out_data, b.data);
                end
                outstanding = 0;
                bc_count++;
                bc_cyc = cyc;
                last_bc_data = bus.out_data; last_bc_tag = bus.out_tag; last_bc_name = bus.out_name;
            end else begin
                chk("out_idle_zero", {bus.out_tag, bus.out_name, bus.out_data}, 64'h0);
            end
            if (!outstanding && bus.work_en) model_capture();
        end
    end

    // ---------------- driver ----------------
    int issue_cyc = 0;

    task automatic wait_ready(output int rc);
        int n;
        n = 0;
        rc = -1;
        while (n < 300) begin
            @(posedge clk); #1;
            bus.work_en = 1'b0;
            #1;
            if (bus.ls_ready) begin rc = cyc; return; end
            n++;
        end
        chk("ready_timeout", bus.ls_ready, 1'b1);
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] base, input logic [31:0] sdata,
                         input logic [31:0] imm, input logic [3:0] tag, input logic [4:0] name);
        int r;
        wait_ready(r);
        bus.work_en = 1'b1; bus.in_op = op; bus.in_base = base; bus.in_sdata = sdata;
        bus.in_imm = imm; bus.in_tag = tag; bus.in_name = name;
        issue_cyc = cyc;
        $display("issue op=%0h base=%08h imm=%08h sdata=%08h tag=%0d name=%0d cycle=%0d",
                 op, base, imm, sdata, tag, name, cyc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c; int r; int b0; int w0; int n;
        logic [5:0] ops [9];
        logic [31:0] base; logic [31:0] imm;
        ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW, OP_BAD};
        bus.work_en = 1'b0; bus.in_op = 6'h0; bus.in_base = 32'h0; bus.in_sdata = 32'h0;
        bus.in_imm = 32'h0; bus.in_tag = 4'h0; bus.in_name = 5'h0;
        preload(32'h104, 8'h78); preload(32'h105, 8'h56); preload(32'h106, 8'h34); preload(32'h107, 8'h12);
        preload(32'h20, 8'h80); preload(32'h21, 8'hFE); preload(32'h22, 8'hFF);
        preload(32'h30, 8'h7F);

        repeat (3) @(posedge clk);
        #3;
        chk("rst_ls_ready", bus.ls_ready, 1'b1);
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 8'h0);
        chk("rst_out_en", bus.out_en, 1'b0);
        chk("rst_out_bus", {bus.out_tag, bus.out_name, bus.out_data}, 64'h0);
        rst = 1'b0;

        // LW: four reads, broadcast at C+9, ready at C+10
        issue(OP_LW, 32'h100, 32'h0, 32'h4, 4'd3, 5'd5); c = issue_cyc;
        wait_ready(r);
        chk("lw_data", last_bc_data, 32'h12345678);
        chk("lw_tag", last_bc_tag, 4'd3);
        chk("lw_name", last_bc_name, 5'd5);
        chk("lw_out_cycle", bc_cyc - c, 9);
        chk("lw_ready_cycle", r - c, 10);

        issue(OP_LB, 32'h20, 32'h0, 32'h0, 4'd1, 5'd1); wait_ready(r);
        chk("lb_data", last_bc_data, 32'hFFFFFF80);
        issue(OP_LBU, 32'h20, 32'h0, 32'h0, 4'd1, 5'd1); wait_ready(r);
        chk("lbu_data", last_bc_data, 32'h00000080);
        issue(OP_LH, 32'h20, 32'h0, 32'h1, 4'd2, 5'd2); c = issue_cyc; wait_ready(r);
        chk("lh_data", last_bc_data, 32'hFFFFFFFE);
        chk("lh_out_cycle", bc_cyc - c, 5);
        issue(OP_LHU, 32'h21, 32'h0, 32'h0, 4'd2, 5'd2); wait_ready(r);
        chk("lhu_data", last_bc_data, 32'h0000FFFE);

        // SW with negative offset
        b0 = bc_count;
        issue(OP_SW, 32'h200, 32'hDEADBEEF, 32'hFFFFFFFC, 4'd1, 5'd2); c = issue_cyc;
        wait_ready(r);
        chk("sw_ready_cycle", r - c, 5);
        chk("sw_mem", {phys_rd(32'h1FF), phys_rd(32'h1FE), phys_rd(32'h1FD), phys_rd(32'h1FC)}, 32'hDEADBEEF);
        chk("sw_no_bc", bc_count, b0);

        // SH with 3 cycles of withheld ack on byte 0
        w0 = wr_count; stall_force = 3;
        issue(OP_SH, 32'h300, 32'h0000A55A, 32'h1, 4'd0, 5'd0); c = issue_cyc;
        wait_ready(r);
        chk("sh_writes", wr_count - w0, 2);
        chk("sh_ready_cycle", r - c, 6);
        chk("sh_mem", {phys_rd(32'h302), phys_rd(32'h301)}, 16'hA55A);

        // Unknown opcode: no traffic, ready next cycle
        b0 = bc_count; w0 = wr_count;
        issue(OP_BAD, 32'h400, 32'h0, 32'h0, 4'd0, 5'd0); c = issue_cyc;
        wait_ready(r);
        chk("bad_ready_cycle", r - c, 1);
        chk("bad_no_effect", {bc_count - b0, wr_count - w0}, 64'h0);

        // Back-to-back issues
        b0 = bc_count;
        issue(OP_LW, 32'h1FC, 32'h0, 32'h0, 4'd4, 5'd4);
        issue(OP_SB, 32'h500, 32'h11, 32'h0, 4'd5, 5'd5);
        issue(OP_LBU, 32'h500, 32'h0, 32'h0, 4'd6, 5'd6);
        issue(OP_SH, 32'h501, 32'h2233, 32'h0, 4'd7, 5'd7);
        issue(OP_LH, 32'h501, 32'h0, 32'h0, 4'd8, 5'd8);
        issue(OP_SW, 32'h510, 32'h44556677, 32'h0, 4'd9, 5'd9);
        wait_ready(r);
        chk("b2b_bc_count", bc_count - b0, 3);
        chk("b2b_last_load", last_bc_data, 32'h00002233);
        chk("b2b_queues_empty", acc_q.size() + bc_q.size(), 0);

        // Randomized stream with ack stalls and rvalid delays
        rand_mode = 1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0) base = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
            else                           base = 32'h1000 + 32'($urandom_range(0, 63));
            imm = 32'($urandom_range(0, 64)) - 32'd32;
            issue(ops[$urandom_range(0, 8)], base, $urandom, imm, 4'($urandom), 5'($urandom));
        end
        wait_ready(r);
        chk("rand_queues_empty", acc_q.size() + bc_q.size(), 0);
        rand_mode = 0;

        // Reset during WAIT of an LW
        delay_force = 6; rd_ack_seen = 0;
        issue(OP_LW, 32'h40, 32'h0, 32'h0, 4'd7, 5'd9);
        n = 0;
        while (!rd_ack_seen && n < 50) begin
            @(posedge clk); #1; bus.work_en = 1'b0; #1; n++;
        end
        chk("rst_test_read_ack", rd_ack_seen, 1'b1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("midrst_ls_ready", bus.ls_ready, 1'b1);
        chk("midrst_mem", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 64'h0);
        chk("midrst_out", {bus.out_en, bus.out_tag, bus.out_name, bus.out_data}, 64'h0);
        b0 = bc_count;
        @(posedge clk); #3;
        rst = 1'b0; delay_force = -1;
        repeat (10) @(posedge clk);
        chk("no_bc_after_rst", bc_count, b0);
        issue(OP_LB, 32'h30, 32'h0, 32'h0, 4'd2, 5'd4); wait_ready(r);
        chk("post_rst_lb", last_bc_data, 32'h0000007F);
        chk("post_rst_bc_count", bc_count, b0 + 1);

        repeat (3) @(posedge clk);
        chk("final_queues_empty", acc_q.size() + bc_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
